// File: rtl/cache_controller.sv
// Sequencer for the set-associative cache_memory array: tag lookup, read-miss refill, write-through stores.
// Define CACHE_CTRL_PLRU_EN for tree pseudo-LRU victims; the default is a per-set round-robin pointer.
module cache_controller #(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4,
  parameter int BLOCK_SIZE = 32,
  localparam int OFF = $clog2(BLOCK_SIZE/4),
  localparam int SET = $clog2(NUM_SETS),
  localparam int WAY = $clog2(NUM_WAYS),
  localparam int TAG = ADDR_SIZE - SET - OFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic                  req_we,
  input  logic [BLOCK_SIZE-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [BLOCK_SIZE-1:0] resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic                  mem_we,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  output logic [WAY-1:0]        cm_way,
  output logic [SET-1:0]        cm_set,
  output logic [TAG-1:0]        cm_tag,
  output logic                  cm_write_enable,
  output logic [BLOCK_SIZE-1:0] cm_write_data,
  input  logic [BLOCK_SIZE-1:0] cm_read_data,
  input  logic [NUM_WAYS-1:0]   cm_hits,
  input  logic [NUM_WAYS-1:0]   cm_valid_flags
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, REFILL} state_t;
  state_t state, state_next;

  logic [ADDR_SIZE-1:0]  addr_lat;
  logic                  we_lat;
  logic [BLOCK_SIZE-1:0] wdata_lat;
  logic [BLOCK_SIZE-1:0] fill_lat;
  logic [SET-1:0]        set_idx;
  logic [WAY-1:0]        hit_way;
  logic [WAY-1:0]        policy_way;
  logic [WAY-1:0]        victim_way;
  logic                  hit;

  // Lowest set bit wins, so an illegal multi-hit still resolves deterministically.
  function automatic logic [WAY-1:0] onehot2bin(input logic [NUM_WAYS-1:0] v);
    logic [WAY-1:0] r;
    r = '0;
    for (int i = NUM_WAYS-1; i >= 0; i--) if (v[i]) r = WAY'(i);
    return r;
  endfunction

  assign set_idx   = addr_lat[OFF+SET-1:OFF];
  assign hit       = |cm_hits;
  assign hit_way   = onehot2bin(cm_hits);
  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    victim_way = policy_way;
    for (int i = NUM_WAYS-1; i >= 0; i--) if (!cm_valid_flags[i]) victim_way = WAY'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      addr_lat  <= req_addr;
      we_lat    <= req_we;
      wdata_lat <= req_wdata;
    end
    if (state == MEM_WAIT && mem_resp_valid) fill_lat <= mem_rdata;
  end

  always_comb begin
    state_next      = state;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    mem_req_valid   = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_wdata       = '0;
    cm_way          = '0;
    cm_set          = '0;
    cm_tag          = '0;
    cm_write_enable = 1'b0;
    cm_write_data   = '0;
    if (!rst) begin
      if (state != IDLE) begin
        cm_set = set_idx;
        cm_tag = addr_lat[ADDR_SIZE-1:OFF+SET];
      end
      unique case (state)
        IDLE: if (req_valid) state_next = LOOKUP;
        LOOKUP: begin
          cm_way = hit_way;
          if (we_lat) begin
            cm_write_enable = hit;
            cm_write_data   = wdata_lat;
            state_next      = MEM_REQ;
          end else if (hit) begin
            resp_valid = 1'b1;
            resp_rdata = cm_read_data;
            state_next = IDLE;
          end else begin
            state_next = MEM_REQ;
          end
        end
        MEM_REQ: begin
          mem_req_valid = 1'b1;
          mem_addr      = addr_lat;
          mem_we        = we_lat;
          mem_wdata     = we_lat ? wdata_lat : '0;
          if (mem_req_ready) state_next = MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            if (we_lat) begin
              resp_valid = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = REFILL;
            end
          end
        end
        REFILL: begin
          cm_way          = victim_way;
          cm_write_enable = 1'b1;
          cm_write_data   = fill_lat;
          resp_valid      = 1'b1;
          resp_rdata      = fill_lat;
          state_next      = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef CACHE_CTRL_PLRU_EN
  // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1; bit 0 is unused.
  logic [NUM_WAYS-1:0] tree [NUM_SETS];

  function automatic logic [WAY-1:0] plru_victim(input logic [NUM_WAYS-1:0] t);
    logic [WAY-1:0] node;
    logic [WAY-1:0] way;
    node = WAY'(1);
    way  = '0;
    for (int l = WAY-1; l >= 0; l--) begin
      way[l] = t[node];
      node   = (node << 1) | WAY'(t[node]);
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS-1:0] plru_touch(input logic [NUM_WAYS-1:0] t,
                                                     input logic [WAY-1:0] w);
    logic [NUM_WAYS-1:0] r;
    logic [WAY-1:0]      node;
    r    = t;
    node = WAY'(1);
    for (int l = WAY-1; l >= 0; l--) begin
      r[node] = ~w[l];
      node    = (node << 1) | WAY'(w[l]);
    end
    return r;
  endfunction

  assign policy_way = plru_victim(tree[set_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
    end else if (state == LOOKUP && !we_lat && hit) begin
      tree[set_idx] <= plru_touch(tree[set_idx], hit_way);
    end else if (state == REFILL) begin
      tree[set_idx] <= plru_touch(tree[set_idx], victim_way);
    end
  end
`else
  logic [WAY-1:0] ptr [NUM_SETS];

  assign policy_way = ptr[set_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) ptr[s] <= '0;
    end else if (state == REFILL) begin
      ptr[set_idx] <= ptr[set_idx] + WAY'(1);
    end
  end
`endif

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state == LOOKUP) |-> $onehot0(cm_hits));

endmodule
